// File: rtl/sqrt_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_arb_pkg
// Description : Shared types, default widths and round-robin helper for the
//               square-root arbiter.
// Revision    : 1.0
// ============================================================================
package sqrt_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int C_DEF_N_REQ          = 4;
    localparam int C_DEF_INT_WIDTH      = 8;
    localparam int C_DEF_FRAC_WIDTH     = 8;
    localparam int C_DEF_TIMEOUT_CYCLES = 64;

    // Index reached by stepping offset positions from base around a ring of n.
    function automatic int unsigned rr_index(input int unsigned base,
                                             input int unsigned offset,
                                             input int unsigned n);
        return (base + offset) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sqrt_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin grant starting the search at ptr.
// Revision    : 1.0
// ============================================================================
module rr_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int N_REQ = C_DEF_N_REQ,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0] ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [N_REQ-1:0] w_rot;
    logic             w_found;

    // Rotating the doubled vector puts requester ptr at bit 0.
    assign w_rot = N_REQ'({req_valid, req_valid} >> ptr);

    always_comb begin
        w_found   = 1'b0;
        grant_idx = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found   = 1'b1;
                grant_idx = IDX_W'(rr_index(32'(ptr), 32'(j), N_REQ));
            end
        end
    end

    assign grant = (enable && w_found) ? (N_REQ'(1) << grant_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/sqrt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_arbiter
// Description : Shares one square-root core between N_REQ requesters, one
//               transaction in flight. Optional watchdog: SQRT_ARB_TIMEOUT_EN.
// Revision    : 1.0
// ============================================================================
module sqrt_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int N_REQ          = C_DEF_N_REQ,
    parameter int INT_WIDTH      = C_DEF_INT_WIDTH,
    parameter int FRAC_WIDTH     = C_DEF_FRAC_WIDTH,
    parameter int TIMEOUT_CYCLES = C_DEF_TIMEOUT_CYCLES
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [N_REQ-1:0]                          req_valid,
    output logic [N_REQ-1:0]                          req_ready,
    input  logic [N_REQ*(INT_WIDTH+FRAC_WIDTH)-1:0]   req_x,
    output logic                                      core_start,
    output logic [INT_WIDTH+FRAC_WIDTH-1:0]           core_x,
    input  logic [INT_WIDTH+FRAC_WIDTH-1:0]           core_sqrt,
    input  logic                                      core_busy,
    input  logic                                      core_valid,
    output logic                                      resp_valid,
    input  logic                                      resp_ready,
    output logic [$clog2(N_REQ)-1:0]                  resp_id,
    output logic [INT_WIDTH+FRAC_WIDTH-1:0]           resp_sqrt,
    output logic                                      resp_err
);

    localparam int C_W   = INT_WIDTH + FRAC_WIDTH;
    localparam int C_IDW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
        $error("sqrt_arbiter: N_REQ must be within 2..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("sqrt_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_t       r_state;
    logic [C_IDW-1:0] r_ptr;
    logic [C_IDW-1:0] r_id;
    logic [C_W-1:0]   r_x;
    logic [C_W-1:0]   r_sqrt;
    logic [N_REQ-1:0] w_grant;
    logic [C_IDW-1:0] w_grant_idx;
    logic             w_arb_en;
    logic             w_core_idle;
    logic             w_tmo_hit;

    // Gating with rst_n keeps every grant low while reset is held.
    assign w_arb_en = rst_n && (r_state == IDLE);

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req_valid (req_valid),
        .ptr       (r_ptr),
        .enable    (w_arb_en),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign req_ready   = w_grant;
    assign w_core_idle = !core_busy && !core_valid;
    assign core_start  = (r_state == ISSUE) && w_core_idle;
    assign core_x      = r_x;
    assign resp_valid  = (r_state == RESP);
    assign resp_id     = r_id;
    assign resp_sqrt   = r_sqrt;

`ifdef SQRT_ARB_TIMEOUT_EN
    localparam int C_TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [C_TW-1:0] r_tmo;
    logic            r_err;

    assign w_tmo_hit = (r_tmo == C_TW'(TIMEOUT_CYCLES - 1)) && !core_valid;
    assign resp_err  = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else if (r_state != WAIT) begin
            r_tmo <= '0;
        end else if (core_valid) begin
            r_err <= 1'b0;
        end else if (w_tmo_hit) begin
            r_err <= 1'b1;
        end else begin
            r_tmo <= r_tmo + C_TW'(1);
        end
    end
`else
    assign w_tmo_hit = 1'b0;
    assign resp_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_x     <= '0;
            r_sqrt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        r_x     <= req_x[int'(w_grant_idx)*C_W +: C_W];
                        r_id    <= w_grant_idx;
                        r_ptr   <= C_IDW'(rr_index(32'(w_grant_idx), 1, N_REQ));
                        r_state <= ISSUE;
                    end
                end
                // Stale core activity must drain before a new start.
                ISSUE: begin
                    if (w_core_idle) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (core_valid) begin
                        r_sqrt  <= core_sqrt;
                        r_state <= RESP;
                    end else if (w_tmo_hit) begin
                        r_sqrt  <= '0;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sqrt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sqrt_arbiter
// Description : Self-checking bench with a latency-programmable core model.
// Revision    : 1.0
// ============================================================================
module tb_sqrt_arbiter;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int IDW = 2;
    localparam int TMO = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_x;
    logic             core_start;
    logic [W-1:0]     core_x;
    logic [W-1:0]     core_sqrt = '0;
    logic             core_busy = 1'b0;
    logic             core_valid = 1'b0;
    logic             resp_valid;
    logic             resp_ready;
    logic [IDW-1:0]   resp_id;
    logic [W-1:0]     resp_sqrt;
    logic             resp_err;

    always #5 clk = ~clk;

    sqrt_arbiter #(
        .N_REQ          (N),
        .INT_WIDTH      (8),
        .FRAC_WIDTH     (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .core_start (core_start),
        .core_x     (core_x),
        .core_sqrt  (core_sqrt),
        .core_busy  (core_busy),
        .core_valid (core_valid),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sqrt  (resp_sqrt),
        .resp_err   (resp_err)
    );

    // Core model: busy for lat cycles after start, then a one-cycle valid.
    int       lat = 16;
    bit       rand_lat = 0;
    bit       never_valid = 0;
    int       core_cnt = 0;
    logic [W-1:0] core_op = '0;

    function automatic logic [W-1:0] core_isqrt(input logic [W-1:0] x);
        longint t;
        int     r;
        if (x[W-1]) return '0;
        t = longint'(x) << 8;
        r = 0;
        while (longint'(r + 1) * longint'(r + 1) <= t) r++;
        return W'(r);
    endfunction

    always @(posedge clk) begin
        core_valid <= 1'b0;
        if (core_start && !core_busy) begin
            core_busy <= 1'b1;
            core_cnt  <= rand_lat ? int'($urandom_range(1, 12)) : lat;
            core_op   <= core_x;
        end else if (core_busy) begin
            if (core_cnt <= 1) begin
                core_busy <= 1'b0;
                if (!never_valid) begin
                    core_valid <= 1'b1;
                    core_sqrt  <= core_isqrt(core_op);
                end
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    typedef struct {
        int           id;
        logic [W-1:0] x;
        logic [W-1:0] sqrt;
        logic         err;
    } exp_t;

    typedef struct {
        int           id;
        logic [W-1:0] x;
        int           l;
        logic [W-1:0] exp_sqrt;
    } vec_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   n_cmp = 0, n_fail = 0, cyc = 0;
    int   n_resp = 0, n_starts = 0, n_grants = 0, n_stall = 0;
    int   last_grant_cyc = 0, last_start_cyc = 0, last_resp_cyc = 0;
    int   model_ptr = 0, hold_low = 0;
    bit   rr_random = 0, rand_req = 0, expect_tmo = 0, prev_stalled = 0;
    logic [IDW-1:0] prev_id;
    logic [W-1:0]   prev_sqrt;
    logic           prev_err;
    int             last_id = 0;
    logic [W-1:0]   last_sqrt = '0;
    logic           last_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] ref_sqrt(input logic [W-1:0] x);
        real v;
        if ($signed(x) < 0) return '0;
        v = $sqrt(real'(x) * 256.0);
        return W'($rtoi($floor(v)));
    endfunction

    function automatic int rr_winner(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [W-1:0] x);
        req_x[i*W +: W] = x;
        req_valid[i]    = 1'b1;
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", req_ready, 0);
        check("rst_core_start", core_start, 0);
        check("rst_core_x", core_x, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_resp_sqrt", resp_sqrt, 0);
        check("rst_resp_err", resp_err, 0);
    endtask

    // One clock: sample just after negedge, apply handshake effects after posedge.
    task automatic step();
        logic [N-1:0]   g;
        logic [N-1:0]   exp_ready;
        logic           rv;
        int             w;
        int             gi;
        exp_t           e;
        logic [IDW-1:0] s_id;
        logic [W-1:0]   s_sqrt;
        logic           s_err;
        @(negedge clk);
        cyc++;
        if (rand_req) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) set_req(i, W'($urandom));
            end
        end
        if (rr_random) resp_ready = 1'($urandom_range(0, 1));
        else if (hold_low > 0 && resp_valid) begin
            resp_ready = 1'b0;
            hold_low--;
        end else resp_ready = 1'b1;
        #1;
        w = rr_winner(req_valid, model_ptr);
        exp_ready = (!rst_n || exp_q.size() > 0 || w < 0) ? '0 : (N'(1) << w);
        check("req_ready", req_ready, exp_ready);
        g = req_ready & req_valid;
        if (core_start) begin
            n_starts++;
            last_start_cyc = cyc;
            check("start_core_idle", {core_busy, core_valid}, 0);
            check("start_in_flight", exp_q.size(), 1);
            if (exp_q.size() > 0) check("core_x", core_x, exp_q[0].x);
        end
        if (prev_stalled) begin
            check("stall_valid", resp_valid, 1);
            check("stall_id", resp_id, prev_id);
            check("stall_sqrt", resp_sqrt, prev_sqrt);
            check("stall_err", resp_err, prev_err);
        end
        prev_stalled = resp_valid && !resp_ready;
        prev_id = resp_id;
        prev_sqrt = resp_sqrt;
        prev_err = resp_err;
        if (prev_stalled) n_stall++;
        rv = resp_valid && resp_ready;
        s_id = resp_id;
        s_sqrt = resp_sqrt;
        s_err = resp_err;
        @(posedge clk);
        #1;
        if (rv) begin
            check("resp_expected", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("resp_id", s_id, e.id);
                check("resp_sqrt", s_sqrt, e.sqrt);
                check("resp_err", s_err, e.err);
            end
            n_resp++;
            last_resp_cyc = cyc;
            last_id = int'(s_id);
            last_sqrt = s_sqrt;
            last_err = s_err;
        end
        if (|g) begin
            gi = 0;
            for (int i = 0; i < N; i++) if (g[i]) gi = i;
            req_valid[gi] = 1'b0;
            e.id = gi;
            e.x = req_x[gi*W +: W];
            e.err = expect_tmo;
            e.sqrt = expect_tmo ? '0 : ref_sqrt(e.x);
            exp_q.push_back(e);
            grant_log.push_back(gi);
            model_ptr = (gi + 1) % N;
            n_grants++;
            last_grant_cyc = cyc;
        end
    endtask

    task automatic run(input string name, input int want, input int bound);
        int base;
        base = n_resp;
        for (int c = 0; c < bound && (n_resp - base) < want; c++) step();
        check(name, n_resp - base, want);
    endtask

    initial begin : main
        vec_t vec[7];
        int   n0;
        int   pend;
        vec[0] = '{1, 16'h1000, 16, 16'h0400};
        vec[1] = '{2, 16'hFF00, 5,  16'h0000};
        vec[2] = '{0, 16'h0100, 3,  16'h0100};
        vec[3] = '{3, 16'h0200, 1,  16'h016A};
        vec[4] = '{1, 16'h7FFF, 8,  16'h0B50};
        vec[5] = '{2, 16'h0000, 2,  16'h0000};
        vec[6] = '{3, 16'h0001, 4,  16'h0010};

        rst_n = 1'b0;
        req_valid = '0;
        req_x = '0;
        resp_ready = 1'b0;
        set_req(2, 16'h1234);
        #2;
        check_reset_outputs();
        req_valid = '0;
        step();
        step();
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++) begin
            lat = vec[k].l;
            n0 = n_starts;
            set_req(vec[k].id, vec[k].x);
            run("vec_resp", 1, 200);
            check("vec_id", last_id, vec[k].id);
            check("vec_sqrt", last_sqrt, vec[k].exp_sqrt);
            check("vec_err", last_err, 0);
            check("vec_starts", n_starts - n0, 1);
            check("vec_start_lat", last_start_cyc - last_grant_cyc, 1);
        end

        lat = 4;
        grant_log.delete();
        set_req(0, 16'h0400);
        set_req(2, 16'h0900);
        set_req(3, 16'h1900);
        run("cont_resp", 3, 300);
        check("cont_n", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            check("cont_order0", grant_log[0], 0);
            check("cont_order1", grant_log[1], 2);
            check("cont_order2", grant_log[2], 3);
        end
        grant_log.delete();
        set_req(3, 16'h0400);
        set_req(0, 16'h0900);
        run("cont2_resp", 2, 200);
        check("cont2_n", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("cont2_order0", grant_log[0], 0);
            check("cont2_order1", grant_log[1], 3);
        end

        hold_low = 10;
        n_stall = 0;
        set_req(1, 16'h2400);
        set_req(2, 16'h0400);
        run("bp_resp", 1, 300);
        check("bp_id", last_id, 1);
        check("bp_sqrt", last_sqrt, 16'h0600);
        check("bp_stall_cycles", n_stall, 10);
        run("bp_next_resp", 1, 200);
        check("bp_next_id", last_id, 2);

        rr_random = 1;
        rand_req = 1;
        rand_lat = 1;
        repeat (400) step();
        rand_req = 0;
        pend = exp_q.size() + $countones(req_valid);
        run("rand_drain", pend, 3000);
        rr_random = 0;
        rand_lat = 0;

        lat = 16;
        n0 = n_starts;
        set_req(1, 16'h0900);
        for (int c = 0; c < 50 && n_starts == n0; c++) step();
        check("rst_started", n_starts - n0, 1);
        repeat (5) step();
        rst_n = 1'b0;
        set_req(3, 16'h3100);
        #1;
        check_reset_outputs();
        exp_q.delete();
        model_ptr = 0;
        prev_stalled = 0;
        step();
        step();
        rst_n = 1'b1;
        run("rst_recover", 1, 200);
        check("rst_recover_id", last_id, 3);
        check("rst_recover_sqrt", last_sqrt, 16'h0700);

`ifdef SQRT_ARB_TIMEOUT_EN
        never_valid = 1;
        expect_tmo = 1;
        lat = 3;
        set_req(2, 16'h1000);
        run("tmo_resp", 1, 100);
        check("tmo_err", last_err, 1);
        check("tmo_sqrt", last_sqrt, 0);
        check("tmo_lat", last_resp_cyc - last_start_cyc, TMO + 1);
        never_valid = 0;
        expect_tmo = 0;
        lat = 2;
        set_req(0, 16'h1000);
        run("tmo_after", 1, 100);
        check("tmo_after_sqrt", last_sqrt, 16'h0400);
`endif

        check("starts_vs_grants", n_starts, n_grants);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
